// File: rtl/add16_arbiter.sv
// Two-requester front end that time-shares a single 16-bit adder.
// Round-robin grant in IDLE, one-cycle EXEC, result held in DONE until taken.
module add16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_z,
  output logic             res_id,
  output logic             res_sign,
  output logic             res_zero,
  output logic             res_carry,
  output logic             res_parity,
  output logic             res_overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic parity;
    logic overflow;
  } flags_t;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_x_q, op_x_d;
  logic [WIDTH-1:0] op_y_q, op_y_d;
  logic             op_id_q, op_id_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_z_q, res_z_d;
  logic             res_id_q, res_id_d;
  flags_t           flags_q, flags_d;
  logic             gnt0, gnt1;
  logic [WIDTH:0]   sum;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    op_id_d      = op_id_q;
    res_valid_d  = res_valid_q;
    res_z_d      = res_z_q;
    res_id_d     = res_id_q;
    flags_d      = flags_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    sum          = {1'b0, op_x_q} + {1'b0, op_y_q};

    case (state_q)
      IDLE: begin
        // Readies are suppressed while rst is high, even though the state already reads IDLE.
        if (!rst) begin
          if (req0_valid && req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
          end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
          end
        end
        if (gnt0 || gnt1) begin
          op_x_d       = gnt1 ? req1_x : req0_x;
          op_y_d       = gnt1 ? req1_y : req0_y;
          op_id_d      = gnt1;
          last_grant_d = gnt1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_z_d          = sum[WIDTH-1:0];
        res_id_d         = op_id_q;
        flags_d.sign     = sum[WIDTH-1];
        flags_d.zero     = (sum[WIDTH-1:0] == '0);
        flags_d.carry    = sum[WIDTH];
        flags_d.parity   = ~^sum[WIDTH-1:0];
        flags_d.overflow = (op_x_q[WIDTH-1] == op_y_q[WIDTH-1]) &&
                           (sum[WIDTH-1] != op_x_q[WIDTH-1]);
        res_valid_d      = 1'b1;
        state_d          = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_z_q      <= '0;
      res_id_q     <= 1'b0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_z_q      <= res_z_d;
      res_id_q     <= res_id_d;
      flags_q      <= flags_d;
    end
  end

  // NOTE: operand registers are pure datapath, always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    op_x_q  <= op_x_d;
    op_y_q  <= op_y_d;
    op_id_q <= op_id_d;
  end

  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;
  assign res_valid    = res_valid_q;
  assign res_z        = res_z_q;
  assign res_id       = res_id_q;
  assign res_sign     = flags_q.sign;
  assign res_zero     = flags_q.zero;
  assign res_carry    = flags_q.carry;
  assign res_parity   = flags_q.parity;
  assign res_overflow = flags_q.overflow;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_add16_arbiter.sv
// Directed self-checking bench for add16_arbiter: flags, latency, round-robin,
// backpressure and mid-operation reset, all with hand-computed expectations.
module tb_add16_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_ready;
  logic [15:0] res_z;
  logic        res_id, res_sign, res_zero, res_carry, res_parity, res_overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  add16_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_id(res_id),
    .res_sign(res_sign), .res_zero(res_zero), .res_carry(res_carry),
    .res_parity(res_parity), .res_overflow(res_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {res_sign, res_zero, res_carry, res_parity, res_overflow};
  endfunction

  // Called at a negedge with the block idle. Expected flags: {sign,zero,carry,parity,overflow}.
  task automatic run_op(input string tag, input bit id, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] ez, input logic [4:0] ef, input int hold);
    logic [15:0] z_seen;
    res_ready = (hold == 0);
    if (id) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    else    begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    #1;
    check({tag, "_ready"}, {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = ~x; req0_y = ~y; req1_x = ~x; req1_y = ~y;
    check({tag, "_exec"}, {busy, res_valid}, 32'd2);
    @(posedge clk); #1;
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_z"}, res_z, ez);
    check({tag, "_flags"}, flags(), ef);
    check({tag, "_id"}, res_id, id);
    z_seen = res_z;
    if (hold > 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold"}, {res_valid, busy, req0_ready, req1_ready, res_z}, {4'b1100, z_seen});
      end
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check({tag, "_pop"}, {res_valid, busy}, 32'd0);
    @(negedge clk);
  endtask

  int gnt_id[$];
  int gnt_cyc[$];

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {res_valid, busy, res_id, flags(), res_z}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("single_req0", 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 5'b01110, 0);
    run_op("pos_ovf",     1'b1, 16'h7FFF, 16'h0001, 16'h8000, 5'b10001, 0);
    run_op("neg_ovf",     1'b0, 16'h8000, 16'h8000, 16'h0000, 5'b01111, 0);
    run_op("all_ones",    1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b10100, 0);
    run_op("backpress",   1'b0, 16'h1234, 16'h1111, 16'h2345, 5'b00010, 5);

    // Round-robin from reset release with both requesters always valid.
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = 16'h0010; req0_y = 16'h0001; req1_x = 16'h0020; req1_y = 16'h0002;
    #1;
    check("rst_readies", {req0_ready, req1_ready, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req0_ready && req1_ready) check("both_ready", 1, 0);
      if (req0_ready || req1_ready) begin
        gnt_id.push_back(req1_ready ? 1 : 0);
        gnt_cyc.push_back(c);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", gnt_id.size(), 4);
    if (gnt_id.size() == 4) begin
      check("rr_order", {gnt_id[0][7:0], gnt_id[1][7:0], gnt_id[2][7:0], gnt_id[3][7:0]}, 32'h00010001);
      check("rr_cycles", {gnt_cyc[0][7:0], gnt_cyc[1][7:0], gnt_cyc[2][7:0], gnt_cyc[3][7:0]}, 32'h00030609);
    end
    @(negedge clk);
    check("rr_idle", {busy, res_valid}, 32'd0);

    // Reset during EXEC after a req0 grant; the following tie must still go to requester 0.
    req0_valid = 1'b1; req0_x = 16'h00AA; req0_y = 16'h0055;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("pre_rst_exec", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst", {res_valid, busy, req0_ready, req1_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = 16'h0101; req0_y = 16'h0202; req1_x = 16'hAAAA; req1_y = 16'h5555;
    #1;
    check("post_rst_tie", {req0_ready, req1_ready, res_valid}, 32'b100);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("post_rst_exec", {busy, res_valid}, 32'd2);
    @(posedge clk); #1;
    check("post_rst_res", {res_valid, res_id, res_z}, {14'd0, 1'b1, 1'b0, 16'h0303});
    check("post_rst_flags", flags(), 5'b00010);
    @(posedge clk); #1;
    check("post_rst_pop", {res_valid, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
